// File: rtl/ctrl_status_regfile.sv
// Multi-channel control/status register file sitting between the AXI slave
// decoder and the per-channel engine controllers. Issues start pulses, tracks
// busy, keeps sticky write-1-to-clear finish flags, counts busy cycles per
// channel and raises a maskable registered interrupt. Reads return one cycle
// after the strobe, and the bus reads 0 on every other cycle.
module ctrl_status_regfile #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_status_en,
  input  logic              axi_status_we,
  input  logic [ADDR_W-1:0] axi_status_addr,
  input  logic [DATA_W-1:0] axi_status_wdata,
  output logic [DATA_W-1:0] axi_status_rdata,
  input  logic [NUM_CH-1:0] ctrl_finish_in,
  output logic              global_en,
  output logic [NUM_CH-1:0] ch_start,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] finish_flag,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(32'h0);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h1);
  localparam logic [ADDR_W-1:0] ADDR_FCLR   = ADDR_W'(32'h2);
  localparam logic [ADDR_W-1:0] ADDR_IRQEN  = ADDR_W'(32'h3);
  localparam logic [ADDR_W-1:0] CNT_BASE    = ADDR_W'(32'h10);

  logic              wr_ctrl;
  logic              wr_fclr;
  logic              wr_irqen;
  logic              rd_strobe;
  logic [NUM_CH-1:0] start_req;
  logic [NUM_CH-1:0] busy_next;
  logic [NUM_CH-1:0] flag_clr;
  logic [NUM_CH-1:0] flag_next;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] irq_en_next;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata_bits;

  // Only the low NUM_CH+1 write-data bits carry meaning for any register.
  assign unused_wdata_bits = ^axi_status_wdata[DATA_W-1:NUM_CH+1];

  assign wr_ctrl   = axi_status_en & axi_status_we & (axi_status_addr == ADDR_CTRL);
  assign wr_fclr   = axi_status_en & axi_status_we & (axi_status_addr == ADDR_FCLR);
  assign wr_irqen  = axi_status_en & axi_status_we & (axi_status_addr == ADDR_IRQEN);
  assign rd_strobe = axi_status_en & ~axi_status_we;

  // Next-state: starts need the enable bit of the same write beat; finish beats start and clear.
  always_comb begin
    start_req   = {NUM_CH{wr_ctrl & axi_status_wdata[0]}} & axi_status_wdata[NUM_CH:1] & ~ch_busy;
    busy_next   = (ch_busy | start_req) & ~ctrl_finish_in;
    flag_clr    = wr_fclr ? axi_status_wdata[NUM_CH-1:0] : '0;
    flag_next   = ctrl_finish_in | (finish_flag & ~flag_clr);
    irq_en_next = wr_irqen ? axi_status_wdata[NUM_CH-1:0] : irq_en;
  end

  // Control, status, interrupt and read-pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      global_en   <= 1'b0;
      ch_start    <= '0;
      ch_busy     <= '0;
      finish_flag <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
    end else begin
      if (wr_ctrl) begin
        global_en <= axi_status_wdata[0];
      end
      ch_start    <= start_req;
      ch_busy     <= busy_next;
      finish_flag <= flag_next;
      irq_en      <= irq_en_next;
      irq         <= |(flag_next & irq_en_next);
      rd_valid    <= rd_strobe;
      if (rd_strobe) begin
        rd_addr <= axi_status_addr;
      end
    end
  end

  // Saturating busy-cycle counters, cleared when their channel starts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (start_req[i]) begin
        cnt[i] <= '0;
      end else if (ch_busy[i] && (cnt[i] != {CNT_W{1'b1}})) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Read mux driven from the captured address and the current register values.
  always_comb begin
    rd_mux = '0;
    if (rd_valid) begin
      case (rd_addr)
        ADDR_CTRL: begin
          rd_mux[0] = global_en;
        end
        ADDR_STATUS: begin
          rd_mux[NUM_CH-1:0]  = finish_flag;
          rd_mux[16 +: NUM_CH] = ch_busy;
        end
        ADDR_IRQEN: begin
          rd_mux[NUM_CH-1:0] = irq_en;
        end
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == (CNT_BASE + ADDR_W'(i))) begin
              rd_mux[CNT_W-1:0] = cnt[i];
            end
          end
        end
      endcase
    end
  end

  assign axi_status_rdata = rd_mux;

endmodule
